// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, registered syncs, blank and
// frame markers, plus a one-clock lookahead for 1-cycle-latency ROM addressing.
module vga_timing_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic [9:0] next_x,
  output logic [9:0] next_y,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_start,
  output logic [7:0] frame_count,
  output logic       running
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX  = 10'(H_TOT - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOT - 1);
  localparam logic [9:0] H_VISL = 10'(H_VIS);
  localparam logic [9:0] V_VISL = 10'(V_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {STOP, RUN, DRAIN} state_t;

  state_t     state_q, state_d;
  logic [9:0] draw_x_q, draw_x_d;
  logic [9:0] draw_y_q, draw_y_d;
  logic [9:0] next_x_q, next_x_d;
  logic [9:0] next_y_q, next_y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_q, blank_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       running_q, running_d;

  function automatic logic [9:0] h_step(input logic [9:0] x);
    return (x == H_MAX) ? 10'd0 : x + 10'd1;
  endfunction

  function automatic logic [9:0] v_step(input logic [9:0] x, input logic [9:0] y);
    if (x != H_MAX) return y;
    return (y == V_MAX) ? 10'd0 : y + 10'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOP:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN:   if (en) state_d = RUN;
               else if (draw_x_q == H_MAX && draw_y_q == V_MAX) state_d = STOP;
      default: state_d = STOP;
    endcase

    // STOP holds at the origin; the STOP->RUN edge keeps (0,0) for the first RUN cycle.
    if (state_q == STOP) begin
      draw_x_d = 10'd0;
      draw_y_d = 10'd0;
    end else begin
      draw_x_d = h_step(draw_x_q);
      draw_y_d = v_step(draw_x_q, draw_y_q);
    end

    // Counters always advance outside STOP, so the lookahead is known one clock early.
    if (state_d == STOP) begin
      next_x_d = 10'd0;
      next_y_d = 10'd0;
    end else begin
      next_x_d = h_step(draw_x_d);
      next_y_d = v_step(draw_x_d, draw_y_d);
    end

    running_d     = (state_d != STOP);
    hs_d          = !(running_d && draw_x_d >= HS_BEG && draw_x_d <= HS_END);
    vs_d          = !(running_d && draw_y_d >= VS_BEG && draw_y_d <= VS_END);
    blank_d       = running_d && (draw_x_d < H_VISL) && (draw_y_d < V_VISL);
    frame_start_d = (state_d == RUN) && (draw_x_d == 10'd0) && (draw_y_d == 10'd0);
    frame_count_d = frame_count_q + {7'd0, frame_start_q};
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q       <= STOP;
      draw_x_q      <= 10'd0;
      draw_y_q      <= 10'd0;
      next_x_q      <= 10'd0;
      next_y_q      <= 10'd0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      draw_x_q      <= draw_x_d;
      draw_y_q      <= draw_y_d;
      next_x_q      <= next_x_d;
      next_y_q      <= next_y_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      running_q     <= running_d;
    end
  end

  assign DrawX       = draw_x_q;
  assign DrawY       = draw_y_q;
  assign next_x      = next_x_q;
  assign next_y      = next_y_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign running     = running_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 16x10 raster (8x5 visible,
// hs at x 10..12, vs at y 6..7, 160-clock frame).
module tb_vga_timing_gen;

  logic       vga_clk, reset, en;
  logic [9:0] draw_x, draw_y, next_x, next_y;
  logic       hs, vs, blank, frame_start, running;
  logic [7:0] frame_count;

  int n_chk = 0, n_fail = 0;
  int la_bad = 0, dec_bad = 0, rng_bad = 0, fs_seen = 0;
  logic mon_en = 1'b0, mon_valid = 1'b0;
  logic [9:0] pnx, pny;

  vga_timing_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(5), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .en(en),
    .DrawX(draw_x), .DrawY(draw_y), .next_x(next_x), .next_y(next_y),
    .hs(hs), .vs(vs), .blank(blank), .frame_start(frame_start),
    .frame_count(frame_count), .running(running)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge vga_clk);
    #1;
  endtask

  task automatic run_until(input logic [9:0] tx, input logic [9:0] ty);
    int n;
    n = 0;
    while (!(draw_x == tx && draw_y == ty) && n < 400) begin
      tick();
      n++;
    end
    chk($sformatf("reach_%0d_%0d", tx, ty), 32'(draw_x == tx && draw_y == ty), 1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_x"}, draw_x, 0);
    chk({pfx, "_y"}, draw_y, 0);
    chk({pfx, "_nx"}, next_x, 0);
    chk({pfx, "_ny"}, next_y, 0);
    chk({pfx, "_hs"}, hs, 1);
    chk({pfx, "_vs"}, vs, 1);
    chk({pfx, "_blank"}, blank, 0);
    chk({pfx, "_fs"}, frame_start, 0);
    chk({pfx, "_fc"}, frame_count, 0);
    chk({pfx, "_run"}, running, 0);
  endtask

  // Continuous lookahead, decode and range watch on every sampled clock.
  always @(negedge vga_clk) begin
    if (mon_en) begin
      if (mon_valid && (draw_x !== pnx || draw_y !== pny)) la_bad++;
      if (hs !== ((draw_x >= 10'd10 && draw_x <= 10'd12) ? 1'b0 : 1'b1)) dec_bad++;
      if (vs !== ((draw_y >= 10'd6 && draw_y <= 10'd7) ? 1'b0 : 1'b1)) dec_bad++;
      if (blank !== (draw_x < 10'd8 && draw_y < 10'd5 && running)) dec_bad++;
      if (draw_x > 10'd15 || draw_y > 10'd9) rng_bad++;
      fs_seen += int'(frame_start);
      pnx = next_x;
      pny = next_y;
      mon_valid = 1'b1;
    end else begin
      mon_valid = 1'b0;
    end
  end

  initial begin
    int hs_lo, vs_lo, bl, fs_f, gap_bad, fs_tot, last_fs, fs0;
    hs_lo = 0; vs_lo = 0; bl = 0; fs_f = 0; gap_bad = 0; fs_tot = 0; last_fs = -1;
    reset = 1'b1;
    en    = 1'b0;
    repeat (3) tick();
    chk_reset_vals("rst");

    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (4) tick();
    chk("stop_hold_run", running, 0);
    chk("stop_hold_x", draw_x, 0);
    chk("stop_hold_hs", hs, 1);

    en = 1'b1;
    tick();
    chk("start_run", running, 1);
    chk("start_x", draw_x, 0);
    chk("start_y", draw_y, 0);
    chk("start_fs", frame_start, 1);
    chk("start_blank", blank, 1);
    chk("start_fc", frame_count, 0);
    chk("start_nx", next_x, 1);

    for (int i = 0; i <= 40960; i++) begin
      if (i < 160) begin
        hs_lo += int'(!hs);
        vs_lo += int'(!vs);
        bl    += int'(blank);
        fs_f  += int'(frame_start);
      end
      if (frame_start) begin
        if (last_fs >= 0 && i - last_fs != 160) gap_bad++;
        last_fs = i;
        fs_tot++;
      end
      if (i == 9)   chk("hs_pre", hs, 1);
      if (i == 10)  chk("hs_first_low", hs, 0);
      if (i == 12)  chk("hs_last_low", hs, 0);
      if (i == 13)  chk("hs_post", hs, 1);
      if (i == 15) begin
        chk("eol_x", draw_x, 15);
        chk("eol_nx", next_x, 0);
        chk("eol_ny", next_y, 1);
      end
      if (i == 16) begin
        chk("line1_x", draw_x, 0);
        chk("line1_y", draw_y, 1);
      end
      if (i == 95)  chk("vs_pre", vs, 1);
      if (i == 96)  chk("vs_first_low", vs, 0);
      if (i == 127) chk("vs_last_low", vs, 0);
      if (i == 128) chk("vs_post", vs, 1);
      if (i == 159) begin
        chk("eof_x", draw_x, 15);
        chk("eof_y", draw_y, 9);
        chk("eof_nx", next_x, 0);
        chk("eof_ny", next_y, 0);
      end
      if (i == 160) begin
        chk("frame_hs_low_clks", hs_lo, 30);
        chk("frame_vs_low_clks", vs_lo, 32);
        chk("frame_blank_clks", bl, 40);
        chk("frame_fs_pulses", fs_f, 1);
        chk("f2_fs", frame_start, 1);
        chk("f2_x", draw_x, 0);
        chk("f2_y", draw_y, 0);
        chk("f2_fc", frame_count, 1);
      end
      if (i == 40800) chk("fc_255", frame_count, 255);
      if (i == 40960) begin
        chk("fc_wrap", frame_count, 0);
        chk("f257_fs", frame_start, 1);
      end
      if (i < 40960) tick();
    end
    chk("fs_gap_bad", gap_bad, 0);
    chk("fs_total", fs_tot, 257);

    // Drain with a re-enable in the middle, then a drain that completes.
    run_until(10'd4, 10'd2);
    en = 1'b0;
    tick();
    chk("drain_x", draw_x, 5);
    chk("drain_run", running, 1);
    fs0 = fs_seen;
    run_until(10'd4, 10'd3);
    en = 1'b1;
    tick();
    chk("resume_x", draw_x, 5);
    chk("resume_y", draw_y, 3);
    run_until(10'd6, 10'd4);
    en = 1'b0;
    run_until(10'd15, 10'd9);
    chk("drain_end_run", running, 1);
    chk("drain_end_nx", next_x, 0);
    chk("drain_end_ny", next_y, 0);
    tick();
    chk("stopped_run", running, 0);
    chk("stopped_x", draw_x, 0);
    chk("stopped_y", draw_y, 0);
    chk("stopped_hs", hs, 1);
    chk("stopped_vs", vs, 1);
    chk("stopped_blank", blank, 0);
    chk("stopped_fs", frame_start, 0);
    chk("stopped_fc", frame_count, 1);
    repeat (5) tick();
    chk("drain_fs_pulses", fs_seen - fs0, 0);
    chk("stop_stay_run", running, 0);

    // Restart, then async reset in the middle of vsync.
    en = 1'b1;
    tick();
    chk("restart_fs", frame_start, 1);
    chk("restart_x", draw_x, 0);
    run_until(10'd3, 10'd6);
    chk("mid_vs", vs, 0);
    chk("mid_fc", frame_count, 2);
    #2;
    reset  = 1'b1;
    mon_en = 1'b0;
    #1;
    chk_reset_vals("async");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_hold_vs", vs, 1);
      chk("rst_hold_run", running, 0);
    end
    en     = 1'b0;
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (3) tick();
    chk("post_rst_run", running, 0);
    chk("post_rst_x", draw_x, 0);

    chk("lookahead_bad", la_bad, 0);
    chk("decode_bad", dec_bad, 0);
    chk("range_bad", rng_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
